// File: rtl/stack_pkg.sv
// Shared constants for the LIFO stack: default sizing, the {push,pop}
// operation encodings, and a ceil-log2 helper for tools without $clog2.
package stack_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 8;

    // Operation encoding formed as {push, pop}
    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    // Smallest r such that 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage array for the LIFO stack: one synchronous write port and one
// synchronous read port with read enable. No reset on the array. A read and
// a write to the same address in one cycle return the old contents, which is
// what replace-top relies on.
module stack_ram
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port; rdata holds when re is low
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with internal count/pointer, full/empty flags, one-cycle error
// pulses, synchronous flush and defined push+pop (replace-top / bypass).
// Optional high-water-mark output hwm enabled by LIFO_STACK_WATERMARK_EN.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
`ifdef LIFO_STACK_WATERMARK_EN
    output logic [CNT_W-1:0]  hwm,
`endif
    output logic              overflow_err,
    output logic              underflow_err
);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] byp_q, byp_d;
    logic              src_ram_q, src_ram_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              ram_we, ram_re;
    logic [PTR_W-1:0]  ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [PTR_W-1:0]  top_addr, next_addr;
    logic              is_full, is_empty;
    logic [1:0]        op;

    assign op        = {push, pop};
    assign is_full   = (count_q == CNT_W'(DEPTH));
    assign is_empty  = (count_q == '0);
    // top_addr wraps when empty; it is never used in that case
    assign top_addr  = PTR_W'(count_q - 1'b1);
    assign next_addr = PTR_W'(count_q);

    // Next-state decode: clear wins, then the {push,pop} operation
    always_comb begin
        count_d     = count_q;
        byp_d       = byp_q;
        src_ram_d   = src_ram_q;
        pop_valid_d = 1'b0;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = next_addr;
        ram_raddr   = top_addr;
        if (clear) begin
            count_d = '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        ram_re      = 1'b1;
                        src_ram_d   = 1'b1;
                        pop_valid_d = 1'b1;
                        count_d     = count_q - 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (is_empty) begin
                        // Bypass: pushed word is returned directly, nothing stored
                        byp_d       = push_data;
                        src_ram_d   = 1'b0;
                        pop_valid_d = 1'b1;
                    end else begin
                        // Replace-top: read old top while overwriting it
                        ram_re      = 1'b1;
                        ram_we      = 1'b1;
                        ram_waddr   = top_addr;
                        src_ram_d   = 1'b1;
                        pop_valid_d = 1'b1;
                    end
                end
                OP_IDLE: ;
                default: ;
            endcase
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            byp_q       <= '0;
            src_ram_q   <= 1'b0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            byp_q       <= byp_d;
            src_ram_q   <= src_ram_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (push_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // pop_data selects between the RAM read register and the bypass register;
    // both only change on an accepted pop, so pop_data holds otherwise.
    assign pop_data      = src_ram_q ? ram_rdata : byp_q;
    assign pop_valid     = pop_valid_q;
    assign full          = is_full;
    assign empty         = is_empty;
    assign count         = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;

`ifdef LIFO_STACK_WATERMARK_EN
    logic [CNT_W-1:0] hwm_q;

    // High-water mark tracks the registered count, one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else if (clear) begin
            hwm_q <= '0;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack with a pop_data scoreboard.
module tb_lifo_stack;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow_err;
    logic              underflow_err;
`ifdef LIFO_STACK_WATERMARK_EN
    logic [CNT_W-1:0]  hwm;
`endif

    lifo_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .push          (push),
        .pop           (pop),
        .push_data     (push_data),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .full          (full),
        .empty         (empty),
        .count         (count),
`ifdef LIFO_STACK_WATERMARK_EN
        .hwm           (hwm),
`endif
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_pop = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop_valid pulse must match the oldest expected word
    always @(posedge clk) begin
        #1;
        if (pop_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop_valid actual=%0h expected=none at %0t", pop_data, $time);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("pop_data", {28'd0, pop_data}, {28'd0, e});
                last_pop = e;
            end
        end
    end

    // Driver: apply one cycle of inputs, return 2 time units after the edge
    task automatic step(input logic p, input logic q, input logic c, input logic [DATA_W-1:0] d);
        push      = p;
        pop       = q;
        clear     = c;
        push_data = d;
        @(posedge clk);
        #2;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;

        // Reset state
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_udf", 32'(underflow_err), 32'd0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("rst_hwm", 32'(hwm), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // 1: push 1,2,3 then pop three times
        step(1, 0, 0, 4'h1); check("t1_count1", 32'(count), 32'd1);
        step(1, 0, 0, 4'h2); check("t1_count2", 32'(count), 32'd2);
        step(1, 0, 0, 4'h3); check("t1_count3", 32'(count), 32'd3);
        check("t1_empty0", 32'(empty), 32'd0);
        exp_q.push_back(4'h3); step(0, 1, 0, 4'h0); check("t1_pcount2", 32'(count), 32'd2);
        exp_q.push_back(4'h2); step(0, 1, 0, 4'h0); check("t1_pcount1", 32'(count), 32'd1);
        exp_q.push_back(4'h1); step(0, 1, 0, 4'h0); check("t1_pcount0", 32'(count), 32'd0);
        check("t1_empty1", 32'(empty), 32'd1);

        // 2: fill to DEPTH, overflow on the ninth push
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 4'(i));
            check("t2_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        check("t2_count8", 32'(count), 32'd8);
        step(1, 0, 0, 4'h8);
        check("t2_ovf", 32'(overflow_err), 32'd1);
        check("t2_count_hold", 32'(count), 32'd8);
        check("t2_full_hold", 32'(full), 32'd1);
        exp_q.push_back(4'h7);
        step(0, 1, 0, 4'h0);
        check("t2_ovf_pulse", 32'(overflow_err), 32'd0);
        check("t2_count7", 32'(count), 32'd7);
        step(0, 0, 1, 4'h0);
        check("t2_clr_count", 32'(count), 32'd0);
        check("t2_clr_empty", 32'(empty), 32'd1);

        // 3: underflow, then bypass
        step(0, 1, 0, 4'h0);
        check("t3_udf", 32'(underflow_err), 32'd1);
        check("t3_udf_valid", 32'(pop_valid), 32'd0);
        check("t3_udf_data", 32'(pop_data), 32'(last_pop));
        check("t3_udf_count", 32'(count), 32'd0);
        step(0, 0, 0, 4'h0);
        check("t3_udf_pulse", 32'(underflow_err), 32'd0);
        exp_q.push_back(4'hA);
        step(1, 1, 0, 4'hA);
        check("t3_byp_valid", 32'(pop_valid), 32'd1);
        check("t3_byp_count", 32'(count), 32'd0);
        check("t3_byp_ovf", 32'(overflow_err), 32'd0);
        check("t3_byp_udf", 32'(underflow_err), 32'd0);
        step(0, 0, 0, 4'h0);
        check("t3_data_hold", 32'(pop_data), 32'hA);

        // 4: replace-top
        step(1, 0, 0, 4'h5);
        step(1, 0, 0, 4'h6);
        exp_q.push_back(4'h6);
        step(1, 1, 0, 4'hC);
        check("t4_swap_count", 32'(count), 32'd2);
        check("t4_swap_ovf", 32'(overflow_err), 32'd0);
        exp_q.push_back(4'hC); step(0, 1, 0, 4'h0);
        exp_q.push_back(4'h5); step(0, 1, 0, 4'h0);
        check("t4_count0", 32'(count), 32'd0);

        // 5: clear together with push
        step(1, 0, 0, 4'h9);
        step(1, 0, 0, 4'hA);
        step(1, 0, 0, 4'hB);
        step(0, 0, 0, 4'h0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("t5_hwm3", 32'(hwm), 32'd3);
`endif
        step(1, 0, 1, 4'hD);
        check("t5_count", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_ovf", 32'(overflow_err), 32'd0);
        check("t5_udf", 32'(underflow_err), 32'd0);
        check("t5_valid", 32'(pop_valid), 32'd0);
`ifdef LIFO_STACK_WATERMARK_EN
        check("t5_hwm0", 32'(hwm), 32'd0);
`endif

        // 6: reset falls while a pop is pending
        step(1, 0, 0, 4'h3);
        step(1, 0, 0, 4'h4);
        pop = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_full", 32'(full), 32'd0);
        check("t6_valid", 32'(pop_valid), 32'd0);
        check("t6_data", 32'(pop_data), 32'd0);
        check("t6_ovf", 32'(overflow_err), 32'd0);
        check("t6_udf", 32'(underflow_err), 32'd0);
        @(posedge clk);
        #1;
        check("t6_valid_edge", 32'(pop_valid), 32'd0);
        pop = 1'b0;
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, 4'h0);
        check("t6_count_after", 32'(count), 32'd0);

        // Every expected pop must have been observed
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
